// File: rtl/loop_addr_gen.sv
// Two-level nested-loop address generator: one command in, outer*inner addresses
// out over a valid/ready stream in row-major order, with last flag and done pulse.
module loop_addr_gen #(
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [CNT_WIDTH-1:0]  outer_extent,
   input  logic [CNT_WIDTH-1:0]  inner_extent,
   input  logic [ADDR_WIDTH-1:0] outer_stride,
   input  logic [ADDR_WIDTH-1:0] inner_stride,
   output logic                  addr_valid,
   input  logic                  addr_ready,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  addr_last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                state;
   logic [CNT_WIDTH-1:0]  i;
   logic [CNT_WIDTH-1:0]  j;
   logic [CNT_WIDTH-1:0]  outer_m1;
   logic [CNT_WIDTH-1:0]  inner_m1;
   logic [ADDR_WIDTH-1:0] out_step;
   logic [ADDR_WIDTH-1:0] in_step;
   logic [ADDR_WIDTH-1:0] row_ptr;

   logic hs;
   logic row_end;
   logic col_end;

   assign hs      = addr_valid & addr_ready;
   assign row_end = (j == inner_m1);
   assign col_end = (i == outer_m1);
   assign busy    = (state == RUN);

   // addr_last is registered, so it is computed from the index values being loaded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         i          <= '0;
         j          <= '0;
         outer_m1   <= '0;
         inner_m1   <= '0;
         out_step   <= '0;
         in_step    <= '0;
         row_ptr    <= '0;
         addr       <= '0;
         addr_valid <= 1'b0;
         addr_last  <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  i        <= '0;
                  j        <= '0;
                  outer_m1 <= outer_extent - CNT_ONE;
                  inner_m1 <= inner_extent - CNT_ONE;
                  out_step <= outer_stride;
                  in_step  <= inner_stride;
                  row_ptr  <= base;
                  addr     <= base;
                  if (outer_extent == '0 || inner_extent == '0) begin
                     state      <= FIN;
                     addr_valid <= 1'b0;
                     addr_last  <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     state      <= RUN;
                     addr_valid <= 1'b1;
                     addr_last  <= (outer_extent == CNT_ONE) && (inner_extent == CNT_ONE);
                  end
               end
            end
            RUN: begin
               if (hs) begin
                  if (!row_end) begin
                     j         <= j + CNT_ONE;
                     addr      <= addr + in_step;
                     addr_last <= col_end && ((j + CNT_ONE) == inner_m1);
                  end else if (!col_end) begin
                     j         <= '0;
                     i         <= i + CNT_ONE;
                     row_ptr   <= row_ptr + out_step;
                     addr      <= row_ptr + out_step;
                     addr_last <= ((i + CNT_ONE) == outer_m1) && (inner_m1 == '0);
                  end else begin
                     state      <= FIN;
                     addr_valid <= 1'b0;
                     addr_last  <= 1'b0;
                     done       <= 1'b1;
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               addr_valid <= 1'b0;
               addr_last  <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_loop_addr_gen.sv
// Directed bench for loop_addr_gen: sweeps, backpressure, wrap, zero extent,
// ignored start, mid-sweep reset and back-to-back commands.
module tb_loop_addr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base;
   logic [7:0]  outer_extent;
   logic [7:0]  inner_extent;
   logic [15:0] outer_stride;
   logic [15:0] inner_stride;
   logic        addr_valid;
   logic        addr_ready;
   logic [15:0] addr;
   logic        addr_last;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_a [8];

   always #5 clk = ~clk;

   loop_addr_gen #(.ADDR_WIDTH(16), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base),
      .outer_extent(outer_extent), .inner_extent(inner_extent),
      .outer_stride(outer_stride), .inner_stride(inner_stride),
      .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
      .addr_last(addr_last), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives start for one edge, then scrambles the command inputs.
   task automatic issue(input logic [15:0] b, input logic [7:0] oe, input logic [7:0] ie,
                        input logic [15:0] os, input logic [15:0] is_);
      base = b; outer_extent = oe; inner_extent = ie;
      outer_stride = os; inner_stride = is_; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      base = 16'hDEAD; outer_extent = 8'hA5; inner_extent = 8'h5A;
      outer_stride = 16'h7777; inner_stride = 16'h3333;
   endtask

   // Consumes n addresses; mode 1 uses ready pattern 1,0,0,1,0,0...
   // poke>=0 pulses start with a different base at that cycle.
   task automatic collect(input string tag, input int n, input int mode, input int poke);
      int k = 0;
      int cyc = 0;
      logic stalled = 1'b0;
      logic [15:0] prev_addr = '0;
      logic prev_last = 1'b0;
      logic r;
      while (k < n && cyc < 60) begin
         chk({tag, "_valid"}, 32'(addr_valid), 32'd1);
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         if (stalled) begin
            chk({tag, "_hold_addr"}, 32'(addr), 32'(prev_addr));
            chk({tag, "_hold_last"}, 32'(addr_last), 32'(prev_last));
         end
         r = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         addr_ready = r;
         if (cyc == poke) begin
            base = 16'h5000; outer_extent = 8'd4; inner_extent = 8'd4; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (r) begin
            chk({tag, "_addr"}, 32'(addr), 32'(exp_a[k]));
            chk({tag, "_last"}, 32'(addr_last), 32'(k == n - 1));
            k++;
         end
         stalled = !r;
         prev_addr = addr;
         prev_last = addr_last;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      addr_ready = 1'b1;
      chk({tag, "_count"}, 32'(k), 32'(n));
      chk({tag, "_end_valid"}, 32'(addr_valid), 32'd0);
      chk({tag, "_end_done"}, 32'(done), 32'd1);
      chk({tag, "_end_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; addr_ready = 1'b1;
      base = '0; outer_extent = '0; inner_extent = '0; outer_stride = '0; inner_stride = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(addr_valid), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_last", 32'(addr_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Basic sweep
      exp_a[0] = 16'h100; exp_a[1] = 16'h102; exp_a[2] = 16'h104;
      exp_a[3] = 16'h110; exp_a[4] = 16'h112; exp_a[5] = 16'h114;
      issue(16'h100, 8'd2, 8'd3, 16'h10, 16'h2);
      collect("basic", 6, 0, -1);
      @(negedge clk);
      chk("basic_done_clear", 32'(done), 32'd0);
      chk("basic_idle_valid", 32'(addr_valid), 32'd0);

      // Backpressure
      issue(16'h100, 8'd2, 8'd3, 16'h10, 16'h2);
      collect("bp", 6, 1, -1);
      @(negedge clk);

      // Wrap-around
      exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
      issue(16'hFFFE, 8'd1, 8'd3, 16'h40, 16'h1);
      collect("wrap", 3, 0, -1);
      @(negedge clk);

      // Zero extent
      issue(16'h300, 8'd0, 8'd5, 16'h10, 16'h1);
      chk("zero_valid", 32'(addr_valid), 32'd0);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("zero_done_clear", 32'(done), 32'd0);
      chk("zero_valid2", 32'(addr_valid), 32'd0);
      chk("zero_busy2", 32'(busy), 32'd0);

      // Ignored start mid-sweep
      exp_a[0] = 16'h100; exp_a[1] = 16'h102; exp_a[2] = 16'h104;
      exp_a[3] = 16'h110; exp_a[4] = 16'h112; exp_a[5] = 16'h114;
      issue(16'h100, 8'd2, 8'd3, 16'h10, 16'h2);
      collect("ign", 6, 0, 2);
      @(negedge clk);

      // Reset mid-sweep
      issue(16'h800, 8'd3, 8'd3, 16'h100, 16'h4);
      repeat (2) @(negedge clk);
      chk("mid_addr", 32'(addr), 32'h808);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_valid", 32'(addr_valid), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_done2", 32'(done), 32'd0);
      chk("mrst_valid2", 32'(addr_valid), 32'd0);
      exp_a[0] = 16'h2000; exp_a[1] = 16'h2003; exp_a[2] = 16'h2020; exp_a[3] = 16'h2023;
      issue(16'h2000, 8'd2, 8'd2, 16'h20, 16'h3);
      collect("fresh", 4, 0, -1);

      // Back-to-back: start in the cycle after done
      @(negedge clk);
      chk("b2b_done_clear", 32'(done), 32'd0);
      exp_a[0] = 16'h0040;
      issue(16'h0040, 8'd1, 8'd1, 16'h0, 16'h0);
      collect("b2b", 1, 0, -1);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
